pwm_capture: RTL

- Receive-side counterpart to the PWM generators: measures an incoming PWM waveform and recovers its high time and period in sys_clk cycles.
- Sits on a PWM input pin, or is looped back from the r/g/b PWM outputs for self-check.
- Each completed period is delivered as one {duty, period} result on a valid/ready interface.
- Detects a stuck-high or stuck-low line.

---
 rtl/pwm_capture.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: recovers high time and period of an asynchronous PWM line
// and hands each completed period out on a valid/ready port.
module pwm_capture #(
    parameter int SIZE = 13
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            PWM_in,
    output logic [SIZE-1:0] duty,
    output logic [SIZE-1:0] period,
    output logic            stuck,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overrun
);

    localparam logic [SIZE-1:0] ONE  = SIZE'(1);
    localparam logic [SIZE-1:0] MAX  = '1;
    localparam logic [SIZE-1:0] NEAR = MAX - ONE;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        STUCK
    } state_t;

    state_t          state;
    logic            s1;
    logic            s2;
    logic            s3;
    logic [SIZE-1:0] per_cnt;
    logic [SIZE-1:0] high_cnt;
    logic            rise;
    logic            level;
    logic            post_meas;
    logic            post_sat;
    logic            post;

    assign rise  = s2 & ~s3;
    assign level = s2;

    // two-flop synchronizer, plus a delay flop for rising-edge detection
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= PWM_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // a rise closes a period; otherwise saturation is flagged on the edge
    // where per_cnt would become all-ones, so it beats a rise one cycle later
    always_comb begin
        post_meas = 1'b0;
        post_sat  = 1'b0;
        if (state == MEASURE && rise) begin
            post_meas = 1'b1;
        end
        if (state != STUCK && !rise && per_cnt == NEAR) begin
            post_sat = 1'b1;
        end
        post = post_meas | post_sat;
    end

    // period and high-time counters; the rise cycle counts as cycle one
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            per_cnt  <= '0;
            high_cnt <= '0;
        end else if (rise) begin
            per_cnt  <= ONE;
            high_cnt <= SIZE'(level);
        end else begin
            if (per_cnt != MAX) begin
                per_cnt <= per_cnt + ONE;
            end
            if (level && high_cnt != MAX) begin
                high_cnt <= high_cnt + ONE;
            end
        end
    end

    // measurement FSM with registered result fields and handshake flags
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            duty      <= '0;
            period    <= '0;
            stuck     <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MEASURE;
                    end else if (post_sat) begin
                        state <= STUCK;
                    end
                end
                MEASURE: begin
                    if (post_sat) begin
                        state <= STUCK;
                    end
                end
                STUCK: begin
                    if (rise) begin
                        state <= MEASURE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (post_meas) begin
                duty   <= high_cnt;
                period <= per_cnt;
                stuck  <= 1'b0;
            end else if (post_sat) begin
                duty   <= level ? MAX : '0;
                period <= MAX;
                stuck  <= 1'b1;
            end

            if (post) begin
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule
